pc_gen16: RTL and testbench
===========================

Name: pc_gen16

Overview:
- Program-counter stage of the 16-bit RISC-V core. It sits both upstream and downstream of the combinational 16-bit adder (S = A + B, truncated to 16 bits).
- Drives the adder operands and registers the adder sum as the next PC.
- Presents fetch addresses to instruction memory with a valid/ready handshake, and handles stalls and branch/jump redirects with a one-cycle flush bubble.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- INC, 16'd2, sequential PC increment (16-bit instruction width).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC and suppress fetch_valid.
- fetch_ready  input  1  instruction memory accepts the current address.
- redir_valid  input  1  branch/jump redirect request.
- redir_base  input  16  redirect base (PC or rs1 value).
- redir_off  input  16  redirect offset (sign-extended immediate).
- add_s  input  16  sum returned from the adder.
- add_a  output  16  adder operand A.
- add_b  output  16  adder operand B.
- pc  output  16  current fetch PC (registered).
- fetch_valid  output  1  pc is a valid fetch request.
- flush  output  1  downstream must discard in-flight instruction (registered).
- fetch_count  output  16  number of accepted fetches, wraps.

Behaviour:
- Reset is asynchronous, active-high. While rst=1:
  - pc=RESET_PC, state=BOOT, flush=0, fetch_count=0.
  - fetch_valid=0.
  - misalign_err=0 (only present when PC_ALIGN_CHECK_EN is defined; see Optional Feature).
- States:
  - BOOT: first cycle after reset release; fetch_valid=0; next state FETCH.
  - FETCH: fetch_valid = !stall.
  - FLUSH: one bubble after a redirect; fetch_valid=0, flush=1; next state FETCH.
- Adder operand mux (combinational):
  - redir_valid=1: add_a=redir_base, add_b=redir_off.
  - Otherwise: add_a=pc, add_b=INC.
- Per-cycle priority: redirect > stall > handshake advance.
  - Redirect: redir_valid=1 in any state. At the edge, pc<=add_s, state<=FLUSH. A handshake completing in the same cycle is not counted; the old address is discarded.
  - Stall: stall=1 with no redirect. pc, state and fetch_count hold; fetch_valid=0. A BOOT or FLUSH state still advances to FETCH.
  - Advance: state=FETCH, stall=0, fetch_ready=1 with no redirect. pc<=add_s (pc+INC), fetch_count<=fetch_count+1.
  - Hold: fetch_valid=1 with fetch_ready=0. pc holds stable until accepted; no change.
- Latency: redirect request to new pc is 1 cycle. The new pc is first presented with fetch_valid=1 two cycles after the request.
- Back-to-back redirects: a redirect in the FLUSH state reloads pc and stays in FLUSH for one more cycle.
- Arithmetic:
  - All sums are 16-bit, carry discarded.
  - 16'hFFFE + INC gives pc=16'h0000 with no error.
  - A negative redir_off (two's complement) wraps the same way.
  - fetch_count wraps 16'hFFFF to 16'h0000.
- Reset mid-operation (any state, including a pending handshake): immediate return to reset values. No fetch is counted.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Adds output misalign_err (1 bit, sticky, cleared only by rst).
  - A redirect whose add_s[0]=1 sets misalign_err. It is otherwise handled as a normal redirect, except pc is loaded with add_s[15:1] followed by 0.
- Not defined:
  - No misalign_err port.
  - pc always loads add_s with bit 0 forced to 0, silently.

Test Plan:
- Reset with RESET_PC=16'h0100, then fetch_ready=1 held -> BOOT cycle with fetch_valid=0; then pc=0100,0102,0104 on consecutive cycles; fetch_count=1,2,3 after each accept.
- fetch_ready=0 for 3 cycles at pc=16'h0104 -> pc stays 0104 with fetch_valid=1; count unchanged; after ready=1, pc=0106.
- stall=1 for 2 cycles at pc=16'h0200 with fetch_ready=1 -> fetch_valid=0; pc and count hold; resume at 0200.
- redir_valid for one cycle, base=16'h0300, off=16'hFFF0, at pc=16'h0310 -> add_a=0300, add_b=FFF0; next cycle pc=02F0 with flush=1 and fetch_valid=0; following cycle fetch_valid=1.
- pc=16'hFFFE accepted -> pc=16'h0000; fetch_count at 16'hFFFF wraps to 0.
- rst asserted mid-FLUSH -> outputs reset asynchronously. With PC_ALIGN_CHECK_EN: redirect to base=16'h0101, off=0 -> pc=0100, misalign_err=1 and it stays 1 until rst.

Source files
------------

// File: rtl/pc_gen16.sv
// pc_gen16: program-counter stage; drives the external adder and registers its sum as the next fetch PC.
// Latency: redirect -> new pc in 1 cycle, new pc presented with fetch_valid 2 cycles after the request.
// Backpressure: pc holds while fetch_ready=0 or stall=1; redirects override both and insert one flush bubble.
// Optional build macro PC_ALIGN_CHECK_EN adds a sticky misalign_err output for odd redirect targets.
module pc_gen16 #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] INC      = 16'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        fetch_ready,
    input  logic        redir_valid,
    input  logic [15:0] redir_base,
    input  logic [15:0] redir_off,
    input  logic [15:0] add_s,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic [15:0] pc,
    output logic        fetch_valid,
    output logic        flush,
    output logic [15:0] fetch_count
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic        misalign_err
`endif
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] pc_nxt;
    logic [15:0] count_nxt;
    logic [15:0] pc_load;

    // Instructions are 16-bit aligned, so bit 0 of any loaded PC is forced low.
    assign pc_load = add_s & 16'hFFFE;

    // Operand mux, fetch request and next-state selection (redirect > stall > advance).
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        count_nxt   = fetch_count;
        add_a       = pc;
        add_b       = INC;
        fetch_valid = (state == FETCH) && !stall;

        if (redir_valid) begin
            add_a     = redir_base;
            add_b     = redir_off;
            pc_nxt    = pc_load;
            state_nxt = FLUSH;
        end else if (stall) begin
            if (state != FETCH) begin
                state_nxt = FETCH;
            end
        end else begin
            case (state)
                BOOT:    state_nxt = FETCH;
                FLUSH:   state_nxt = FETCH;
                FETCH: begin
                    if (fetch_ready) begin
                        pc_nxt    = pc_load;
                        count_nxt = fetch_count + 16'd1;
                    end
                end
                default: state_nxt = BOOT;
            endcase
        end
    end

    // State, PC, accepted-fetch counter and the registered flush flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            fetch_count <= 16'd0;
            flush       <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            fetch_count <= count_nxt;
            flush       <= (state_nxt == FLUSH);
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // Sticky flag for a redirect that targets an odd address; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else if (redir_valid && add_s[0]) begin
            misalign_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_gen16.sv
// tb_pc_gen16: scoreboard bench for pc_gen16 with a behavioural adder closing the add_a/add_b/add_s loop.
// Inputs change on the falling edge; registered outputs are compared on the falling edge.
// Accepted fetch addresses are popped from a queue of expected addresses filled by the stimulus.
module tb_pc_gen16;

    localparam logic [15:0] RST_PC = 16'h0100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall;
    logic        fetch_ready;
    logic        redir_valid;
    logic [15:0] redir_base;
    logic [15:0] redir_off;
    logic [15:0] add_s;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic [15:0] pc;
    logic        fetch_valid;
    logic        flush;
    logic [15:0] fetch_count;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign_err;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] sb_q[$];
    logic [15:0] exp_count = 16'd0;
    logic [15:0] ea;

    always #5 clk = ~clk;

    // The external 16-bit adder, carry discarded.
    assign add_s = add_a + add_b;

    pc_gen16 #(
        .RESET_PC (RST_PC),
        .INC      (16'd2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .fetch_ready (fetch_ready),
        .redir_valid (redir_valid),
        .redir_base  (redir_base),
        .redir_off   (redir_off),
        .add_s       (add_s),
        .add_a       (add_a),
        .add_b       (add_b),
        .pc          (pc),
        .fetch_valid (fetch_valid),
        .flush       (flush),
        .fetch_count (fetch_count)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misalign_err(misalign_err)
`endif
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Redirect to base+off, then wait through the bubble; returns in FETCH with fetch_ready low.
    task automatic redir_to(input logic [15:0] b, input logic [15:0] o);
        redir_valid = 1'b1;
        redir_base  = b;
        redir_off   = o;
        fetch_ready = 1'b0;
        stall       = 1'b0;
        @(negedge clk);
        redir_valid = 1'b0;
        @(negedge clk);
    endtask

    // Scoreboard monitor: a completed, non-redirected handshake must present the next expected address.
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            exp_count = 16'd0;
        end else if (fetch_valid && fetch_ready && !redir_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow got=%h exp=none", pc);
            end else begin
                check("sb_fetch_addr", pc, sb_q.pop_front());
            end
            exp_count = exp_count + 16'd1;
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stall       = 1'b0;
        fetch_ready = 1'b0;
        redir_valid = 1'b0;
        redir_base  = 16'h0000;
        redir_off   = 16'h0000;
        #1 rst = 1'b1;
        #1;
        check("rst_pc", pc, RST_PC);
        check("rst_fv", 16'(fetch_valid), 16'h0);
        check("rst_flush", 16'(flush), 16'h0);
        check("rst_count", fetch_count, 16'h0000);

        // Sequential fetch with fetch_ready held high.
        sb_q.push_back(16'h0100);
        sb_q.push_back(16'h0102);
        sb_q.push_back(16'h0104);
        @(negedge clk);
        rst = 1'b0;
        fetch_ready = 1'b1;
        #1 check("boot_fv", 16'(fetch_valid), 16'h0);
        @(negedge clk);
        check("seq0_pc", pc, 16'h0100);
        check("seq0_fv", 16'(fetch_valid), 16'h1);
        check("seq0_count", fetch_count, 16'h0000);
        @(negedge clk);
        check("seq1_pc", pc, 16'h0102);
        check("seq1_count", fetch_count, 16'h0001);
        @(negedge clk);
        check("seq2_pc", pc, 16'h0104);
        check("seq2_count", fetch_count, 16'h0002);

        // Not ready: address held stable with fetch_valid asserted.
        fetch_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("hold_pc", pc, 16'h0104);
            check("hold_fv", 16'(fetch_valid), 16'h1);
            check("hold_count", fetch_count, exp_count);
        end
        fetch_ready = 1'b1;
        @(negedge clk);
        check("resume_pc", pc, 16'h0106);
        check("resume_count", fetch_count, 16'h0003);
        fetch_ready = 1'b0;

        // Stall at 0x0200 with fetch_ready high.
        redir_valid = 1'b1;
        redir_base  = 16'h0200;
        redir_off   = 16'h0000;
        #1;
        check("stall_redir_a", add_a, 16'h0200);
        check("stall_redir_b", add_b, 16'h0000);
        @(negedge clk);
        check("stall_flush_pc", pc, 16'h0200);
        check("stall_flush", 16'(flush), 16'h1);
        check("stall_flush_fv", 16'(fetch_valid), 16'h0);
        redir_valid = 1'b0;
        fetch_ready = 1'b1;
        stall       = 1'b1;
        @(negedge clk);
        check("stall_flush_clr", 16'(flush), 16'h0);
        repeat (2) begin
            check("stall_pc", pc, 16'h0200);
            check("stall_fv", 16'(fetch_valid), 16'h0);
            check("stall_count", fetch_count, 16'h0003);
            @(negedge clk);
        end
        stall = 1'b0;
        sb_q.push_back(16'h0200);
        #1 check("unstall_fv", 16'(fetch_valid), 16'h1);
        @(negedge clk);
        check("unstall_pc", pc, 16'h0202);
        check("unstall_count", fetch_count, 16'h0004);
        fetch_ready = 1'b0;

        // Backward redirect with a handshake in the same cycle that must not count.
        redir_to(16'h0310, 16'h0000);
        check("pre_redir_pc", pc, 16'h0310);
        redir_valid = 1'b1;
        redir_base  = 16'h0300;
        redir_off   = 16'hFFF0;
        fetch_ready = 1'b1;
        #1;
        check("redir_add_a", add_a, 16'h0300);
        check("redir_add_b", add_b, 16'hFFF0);
        @(negedge clk);
        check("redir_pc", pc, 16'h02F0);
        check("redir_flush", 16'(flush), 16'h1);
        check("redir_fv", 16'(fetch_valid), 16'h0);
        check("redir_count", fetch_count, 16'h0004);
        redir_valid = 1'b0;
        sb_q.push_back(16'h02F0);
        @(negedge clk);
        check("post_redir_fv", 16'(fetch_valid), 16'h1);
        check("post_redir_flush", 16'(flush), 16'h0);
        check("post_redir_pc", pc, 16'h02F0);
        @(negedge clk);
        check("post_redir_next", pc, 16'h02F2);
        check("post_redir_count", fetch_count, exp_count);
        fetch_ready = 1'b0;

        // Back-to-back redirects keep the bubble going.
        redir_valid = 1'b1;
        redir_base  = 16'h0400;
        redir_off   = 16'h0000;
        @(negedge clk);
        check("b2b_first_pc", pc, 16'h0400);
        redir_base = 16'h0500;
        @(negedge clk);
        check("b2b_pc", pc, 16'h0500);
        check("b2b_flush", 16'(flush), 16'h1);
        check("b2b_fv", 16'(fetch_valid), 16'h0);
        redir_valid = 1'b0;
        @(negedge clk);
        check("b2b_end_flush", 16'(flush), 16'h0);
        check("b2b_end_fv", 16'(fetch_valid), 16'h1);

        // Odd redirect target: bit 0 dropped.
        redir_to(16'h0101, 16'h0000);
        check("odd_pc", pc, 16'h0100);
`ifdef PC_ALIGN_CHECK_EN
        check("misalign_set", 16'(misalign_err), 16'h1);
        @(negedge clk);
        check("misalign_sticky", 16'(misalign_err), 16'h1);
`endif

        // PC wraps FFFE -> 0000, then run until fetch_count wraps.
        redir_to(16'hFFF0, 16'h000E);
        check("wrap_start_pc", pc, 16'hFFFE);
        sb_q.push_back(16'hFFFE);
        fetch_ready = 1'b1;
        @(negedge clk);
        check("wrap_pc", pc, 16'h0000);
        ea = 16'h0000;
        for (int i = 0; i < 70000 && fetch_count != 16'hFFFF; i++) begin
            sb_q.push_back(ea);
            ea = ea + 16'd2;
            @(negedge clk);
        end
        check("count_at_max", fetch_count, 16'hFFFF);
        check("count_model", fetch_count, exp_count);
        check("long_run_pc", pc, ea);
        sb_q.push_back(ea);
        @(negedge clk);
        check("count_wrap", fetch_count, 16'h0000);
        fetch_ready = 1'b0;

        // Asynchronous reset while flushing.
        redir_valid = 1'b1;
        redir_base  = 16'h0700;
        redir_off   = 16'h0000;
        @(negedge clk);
        check("pre_rst_flush", 16'(flush), 16'h1);
        redir_valid = 1'b0;
        fetch_ready = 1'b1;
        rst = 1'b1;
        #1;
        check("arst_pc", pc, RST_PC);
        check("arst_flush", 16'(flush), 16'h0);
        check("arst_fv", 16'(fetch_valid), 16'h0);
        check("arst_count", fetch_count, 16'h0000);
`ifdef PC_ALIGN_CHECK_EN
        check("arst_misalign", 16'(misalign_err), 16'h0);
`endif
        @(negedge clk);
        check("sb_empty", 16'(sb_q.size()), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
